// File: rtl/uart_rx_module.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit start validation and
// centre-of-bit sampling, with one-cycle done/framing-error strobes.
module uart_rx_module #(
  parameter logic [12:0] BPS = 13'd434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en_sig,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_err
);

  localparam logic [12:0] HALF_LAST = (BPS >> 1) - 13'd1;
  localparam logic [12:0] BIT_LAST  = BPS - 13'd1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic        sync1_reg, rx_s_reg, rx_q_reg;
  logic [1:0]  settle_reg;
  logic [12:0] c1_reg, c1_next;
  logic [2:0]  idx_reg, idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  data_reg, data_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic        fe, half_hit, bit_hit, data_sample;

  // The sync flops are preset to idle on reset; if the real line is low at
  // that moment the flush would look like a falling edge, so edges are masked
  // until the chain has refilled with the true pin level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg  <= 1'b1;
      rx_s_reg   <= 1'b1;
      rx_q_reg   <= 1'b1;
      settle_reg <= 2'd3;
    end else begin
      sync1_reg <= rx_pin;
      rx_s_reg  <= sync1_reg;
      rx_q_reg  <= rx_s_reg;
      if (settle_reg != 2'd0)
        settle_reg <= settle_reg - 2'd1;
    end
  end

  assign fe          = rx_q_reg & ~rx_s_reg & (settle_reg == 2'd0);
  assign half_hit    = (c1_reg == HALF_LAST);
  assign bit_hit     = (c1_reg == BIT_LAST);
  assign data_sample = (state_reg == DATA) && bit_hit && rx_en_sig;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_shift
      assign shift_next[gi] = (data_sample && (idx_reg == 3'(gi))) ? rx_s_reg : shift_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      c1_reg    <= 13'd0;
      idx_reg   <= 3'd0;
      shift_reg <= 8'h00;
      data_reg  <= 8'h00;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      c1_reg    <= c1_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    c1_next    = c1_reg + 13'd1;
    idx_next   = idx_reg;
    data_next  = data_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    if (!rx_en_sig) begin
      state_next = IDLE;
      c1_next    = 13'd0;
      idx_next   = 3'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          c1_next  = 13'd0;
          idx_next = 3'd0;
          if (fe)
            state_next = START;
        end
        START: begin
          if (half_hit) begin
            c1_next    = 13'd0;
            state_next = rx_s_reg ? IDLE : DATA;
          end
        end
        DATA: begin
          if (bit_hit) begin
            c1_next  = 13'd0;
            idx_next = idx_reg + 3'd1;
            if (idx_reg == 3'd7)
              state_next = STOP;
          end
        end
        STOP: begin
          if (bit_hit) begin
            c1_next = 13'd0;
            if (rx_s_reg) begin
              data_next  = shift_reg;
              done_next  = 1'b1;
              state_next = IDLE;
            end else begin
              err_next   = 1'b1;
              state_next = BRK;
            end
          end
        end
        BRK: begin
          // Hold off until the line is released so a long break is one error.
          c1_next = 13'd0;
          if (rx_s_reg)
            state_next = IDLE;
        end
        default: begin
          c1_next    = 13'd0;
          state_next = IDLE;
        end
      endcase
    end
  end

  assign rx_data = data_reg;
  assign rx_done = done_reg;
  assign rx_err  = err_reg;

endmodule

// File: tb/tb_uart_rx_module.sv
// Bench for uart_rx_module: vector table, hand-written corner sequences and
// randomised frames against a frame-level model, at BPS=16 and BPS=17.
module tb_uart_rx_module;

  localparam int B  = 16;
  localparam int H  = B / 2;
  localparam int B2 = 17;

  logic       clk = 1'b0;
  logic       rst, en, line, sel_b;
  logic       pin_a, pin_b;
  logic [7:0] data_a, data_b;
  logic       done_a, err_a, done_b, err_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt_a = 0, err_cnt_a = 0, done_cnt_b = 0, err_cnt_b = 0;
  int excl_viol = 0;
  int done_t_a[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       en;
    int         px;
    int         hold;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign pin_a = sel_b ? 1'b1 : line;
  assign pin_b = sel_b ? line : 1'b1;

  uart_rx_module #(.BPS(13'd16)) dut_a (
    .clk(clk), .rst(rst), .rx_en_sig(en), .rx_pin(pin_a),
    .rx_data(data_a), .rx_done(done_a), .rx_err(err_a)
  );

  uart_rx_module #(.BPS(13'd17)) dut_b (
    .clk(clk), .rst(rst), .rx_en_sig(en), .rx_pin(pin_b),
    .rx_data(data_b), .rx_done(done_b), .rx_err(err_b)
  );

  always @(negedge clk) begin
    if (done_a) begin
      done_cnt_a++;
      done_t_a.push_back(cyc);
    end
    if (err_a) err_cnt_a++;
    if (done_b) done_cnt_b++;
    if (err_b) err_cnt_b++;
    if ((done_a && err_a) || (done_b && err_b)) excl_viol++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      $display("ok   %s: %0d (0x%0h)", name, act, act);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller is positioned 1 time unit after a rising edge; px is the bit
  // period in hundredths of a clock so baud error can be modelled.
  task automatic send_frame(input logic [7:0] b, input logic stopb, input int px, input int hold);
    logic [9:0] bits;
    int t;
    bits = {stopb, b, 1'b0};
    start_cyc = cyc;
    for (int k = 0; k < 10; k++) begin
      line = bits[k];
      t = ((k + 1) * px + 50) / 100 - (k * px + 50) / 100;
      repeat (t) @(posedge clk);
      #1;
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
    end
    line = 1'b1;
  endtask

  initial begin
    int d0, e0, t1, t2, s1, px, gap;
    int pxs[3];
    logic [7:0] b, exp_data;
    logic st;

    rst = 1'b1; en = 1'b1; line = 1'b1; sel_b = 1'b0;
    idle(3);
    chk("reset_data_a", int'(data_a), 0);
    chk("reset_done_a", int'(done_a), 0);
    chk("reset_err_a", int'(err_a), 0);
    chk("reset_data_b", int'(data_b), 0);
    rst = 1'b0;
    idle(2 * B);

    vecs[0] = '{8'h55, 1'b1, 1'b1, 1600, 0,  1, 0, 8'h55};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1600, 0,  1, 0, 8'hA5};
    vecs[2] = '{8'hFF, 1'b0, 1'b1, 1600, 40, 0, 1, 8'hA5};
    vecs[3] = '{8'h81, 1'b1, 1'b1, 1600, 0,  1, 0, 8'h81};
    vecs[4] = '{8'h77, 1'b1, 1'b0, 1600, 0,  0, 0, 8'h81};
    vecs[5] = '{8'h0F, 1'b1, 1'b1, 1632, 0,  1, 0, 8'h0F};
    vecs[6] = '{8'h99, 1'b1, 1'b1, 1568, 0,  1, 0, 8'h99};

    for (int i = 0; i < 7; i++) begin
      en = vecs[i].en;
      d0 = done_cnt_a; e0 = err_cnt_a;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].px, vecs[i].hold);
      idle(2 * B);
      chk($sformatf("vec%0d_done", i), done_cnt_a - d0, vecs[i].exp_done);
      chk($sformatf("vec%0d_err", i), err_cnt_a - e0, vecs[i].exp_err);
      chk($sformatf("vec%0d_data", i), int'(data_a), int'(vecs[i].exp_data));
      en = 1'b1;
      idle(B);
    end

    // back-to-back frames with no idle gap, plus start-to-done latency
    d0 = done_cnt_a;
    send_frame(8'hA5, 1'b1, 1600, 0);
    s1 = start_cyc;
    chk("b2b_first_data", int'(data_a), 8'hA5);
    send_frame(8'h3C, 1'b1, 1600, 0);
    idle(2 * B);
    chk("b2b_count", done_cnt_a - d0, 2);
    t1 = done_t_a[$ - 1];
    t2 = done_t_a[$];
    chk_rng("b2b_latency", t1 - (s1 + 2), H + 9 * B - 1, H + 9 * B + 1);
    chk("b2b_spacing", t2 - t1, 10 * B);
    chk("b2b_second_data", int'(data_a), 8'h3C);

    // 5-clock glitch must not start a frame
    d0 = done_cnt_a; e0 = err_cnt_a;
    line = 1'b0;
    idle(5);
    line = 1'b1;
    idle(2 * B);
    chk("glitch_done", done_cnt_a - d0, 0);
    chk("glitch_err", err_cnt_a - e0, 0);
    send_frame(8'h0F, 1'b1, 1600, 0);
    idle(2 * B);
    chk("glitch_next_done", done_cnt_a - d0, 1);
    chk("glitch_next_data", int'(data_a), 8'h0F);

    // reset in the middle of data bit 4
    d0 = done_cnt_a; e0 = err_cnt_a;
    fork
      send_frame(8'hC3, 1'b1, 1600, 0);
      begin
        idle(B + 4 * B + H);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("midrst_data", int'(data_a), 0);
        chk("midrst_strobe", int'(done_a | err_a), 0);
      end
    join
    idle(2 * B);
    chk("midrst_done", done_cnt_a - d0, 0);
    chk("midrst_err", err_cnt_a - e0, 0);
    send_frame(8'h5A, 1'b1, 1600, 0);
    idle(2 * B);
    chk("midrst_next_done", done_cnt_a - d0, 1);
    chk("midrst_next_data", int'(data_a), 8'h5A);

    // enable dropped during data bit 2
    d0 = done_cnt_a; e0 = err_cnt_a;
    fork
      send_frame(8'hE7, 1'b1, 1600, 0);
      begin
        idle(B + 2 * B + H);
        en = 1'b0;
      end
    join
    idle(B);
    en = 1'b1;
    idle(B);
    chk("endrop_done", done_cnt_a - d0, 0);
    chk("endrop_err", err_cnt_a - e0, 0);
    send_frame(8'h99, 1'b1, 1600, 0);
    idle(2 * B);
    chk("endrop_next_done", done_cnt_a - d0, 1);
    chk("endrop_next_data", int'(data_a), 8'h99);

    // odd bit period on the second instance, ideal and +-2% line rate
    sel_b = 1'b1;
    idle(B2);
    pxs = '{1700, 1666, 1734};
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      d0 = done_cnt_b;
      send_frame(b, 1'b1, pxs[i], 0);
      idle(2 * B2);
      chk($sformatf("bps17_%0d_done", i), done_cnt_b - d0, 1);
      chk($sformatf("bps17_%0d_data", i), int'(data_b), int'(b));
    end
    sel_b = 1'b0;
    idle(2 * B);

    // randomised frames against the frame-level model
    pxs = '{1568, 1600, 1632};
    exp_data = data_a;
    for (int n = 0; n < 40; n++) begin
      b   = 8'($urandom_range(0, 255));
      st  = ($urandom_range(0, 7) != 0);
      px  = pxs[$urandom_range(0, 2)];
      gap = st ? int'($urandom_range(0, 20)) : int'($urandom_range(16, 30));
      d0 = done_cnt_a; e0 = err_cnt_a;
      send_frame(b, st, px, 0);
      if (st) exp_data = b;
      chk($sformatf("rand%0d_done", n), done_cnt_a - d0, st ? 1 : 0);
      chk($sformatf("rand%0d_err", n), err_cnt_a - e0, st ? 0 : 1);
      chk($sformatf("rand%0d_data", n), int'(data_a), int'(exp_data));
      idle(gap);
    end
    idle(2 * B);

    chk("strobe_exclusive", excl_viol, 0);
    chk("b_total_done", done_cnt_b, 3);
    chk("b_total_err", err_cnt_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
